lsu_dmem: RTL and testbench
===========================

# lsu_dmem

Load/store unit between the decode/control stage and the data-memory bus of the RISC-V core. Consumes `dmem_req`, `dmem_wr`, `dmem_size` and `dmem_zero_ex` from control, plus the ALU address and rs2 data. Runs a valid/ready bus transaction with byte-lane alignment and load sign/zero extension. Holds the core with `stall` until the access completes.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.
- `TIMEOUT`, default 255: maximum cycles spent in REQ+WAIT before abort; 0 disables the timeout.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `dmem_req` in 1: access requested by the current instruction.
- `dmem_wr` in 1: 1 = store, 0 = load.
- `dmem_size` in `op_dmem_size`: `OP_DMEM_BYTE`, `OP_DMEM_HALF` or `OP_DMEM_WORD`.
- `dmem_zero_ex` in 1: 1 = zero-extend load result, 0 = sign-extend.
- `addr` in ADDR_W: byte address (ALU result).
- `wr_data` in 32: store data (rs2).
- `rd_data` out 32: aligned, extended load result.
- `stall` out 1: hold PC and register-file write.
- `bus_err` out 1: one-cycle pulse on timeout abort.
- `bus_valid` out 1: request valid.
- `bus_ready` in 1: request accepted.
- `bus_addr` out ADDR_W: word-aligned address (`addr[1:0]` forced to 0).
- `bus_we` out 1: write enable.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_rvalid` in 1: read data valid.
- `bus_rdata` in 32: read data.
- `misalign` out 1: present only with `LSU_MISALIGN_TRAP_EN`.

## Operation
State machine IDLE, REQ, WAIT, DONE:
- IDLE:
  - `dmem_req`=1: register `bus_addr`/`bus_we`/`bus_be`/`bus_wdata`, plus offset, size and zero_ex; go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `bus_valid`=1, with all bus outputs held stable until `bus_ready`.
  - On handshake: a store goes to DONE; a load goes to WAIT.
- WAIT:
  - On `bus_rvalid`: capture `bus_rdata` and go to DONE.
  - `bus_rvalid` is ignored in every other state.
- DONE:
  - Exactly one cycle; `stall`=0 so the core retires the instruction.
  - Unconditionally returns to IDLE. No re-issue is possible because the next instruction is presented in the following cycle.
- `stall` = `dmem_req` & (state != DONE). This is combinational, so stall is already 1 in the IDLE cycle that sees the request.

Store lane rules (`o` = `addr[1:0]`):
- Byte: `bus_be` = 1<<o; `bus_wdata` = {4{`wr_data[7:0]`}}.
- Half: `bus_be` = `o[1]` ? 4'b1100 : 4'b0011; `bus_wdata` = {2{`wr_data[15:0]`}}.
- Word: `bus_be` = 4'b1111; `bus_wdata` = `wr_data`.

Load rules:
- Shift the captured data right by 8·o for byte, or 16·`o[1]` for half.
- Take the low 8 or 16 bits; zero-extend if `zero_ex`, else sign-extend.
- Word loads pass the data through unchanged.
- `rd_data` holds its value until the next load completes.

Timeout (only when TIMEOUT ≠ 0):
- Counter clears on IDLE→REQ and increments every cycle in REQ or WAIT.
- When the counter reaches TIMEOUT: drop `bus_valid`, go to DONE, pulse `bus_err`, set `rd_data`=0.

## Timing
- Reset values: state IDLE; `bus_valid`, `bus_we` = 0; `bus_be`, `bus_addr`, `bus_wdata`, `rd_data` = 0; `bus_err` = 0; `misalign` = 0. `stall` follows `dmem_req`.
- Minimum latencies with `bus_ready`=1 at first REQ cycle:
  - Store: 3 cycles (IDLE, REQ, DONE).
  - Load: 4 cycles, with `bus_rvalid` the cycle after the handshake.
- `bus_rvalid` is never asserted in the handshake cycle itself; the earliest is one cycle later.
- Reset asserted mid-transaction: immediate return to IDLE with `bus_valid`=0. Any in-flight `bus_rvalid` after reset is ignored.
- `dmem_req` dropping in REQ/WAIT (not legal from the core) does not abort the transaction.

## Configuration
- Macro `LSU_MISALIGN_TRAP_EN` defined:
  - Half access with `addr[0]`=1, or word access with `addr[1:0]`≠0, issues no bus transaction.
  - IDLE goes directly to DONE; `misalign` pulses for the DONE cycle; `rd_data`=0.
- Macro not defined:
  - No `misalign` port.
  - Half accesses use the lanes selected by `addr[1]`; word accesses ignore `addr[1:0]`. Extraction follows the same rule.

## Test plan
- Store byte, `addr`=0x103, `wr_data`=0xA5 → `bus_be`=4'b1000, `bus_wdata`=0xA5A5A5A5, `bus_addr`=0x100; `stall` high 2 cycles then low 1 cycle.
- Load half signed, `addr`=0x202, `bus_rdata`=0x8001_1234 → `rd_data`=0xFFFF8001; same access with `dmem_zero_ex`=1 → 0x00008001.
- `bus_ready` held low 5 cycles → `bus_valid` and all bus outputs stable throughout; load completes in 9 cycles total.
- TIMEOUT=4, `bus_rvalid` never asserted → `bus_err` pulses exactly once, `rd_data`=0, state returns to IDLE.
- `rst_n` low during WAIT, then `bus_rvalid` pulsed → all outputs at reset values, no DONE cycle, `rd_data`=0.
- With `LSU_MISALIGN_TRAP_EN`, word load at 0x301 → no `bus_valid`, `misalign`=1 for one cycle, `stall` high only 1 cycle.

Source files
------------

// File: rtl/lsu_dmem.sv
// lsu_dmem: load/store unit between the control stage and the data-memory bus.
//
// Takes one access request from control, runs a valid/ready bus transaction
// with byte-lane alignment, and returns an aligned, sign/zero-extended load
// result. `stall` holds the core until the access completes.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   dmem_req/wr/size/zero_ex   access request from control
//   addr, wr_data              byte address (ALU result), store data (rs2)
//   rd_data                    aligned/extended load result, held until next load
//   stall                      hold PC and register-file write
//   bus_err                    one-cycle pulse on timeout abort
//   bus_valid/ready            request handshake
//   bus_addr/we/be/wdata       word-aligned request, lane-replicated store data
//   bus_rvalid/rdata           read data return
//   misalign                   (LSU_MISALIGN_TRAP_EN only) pulse on trapped access
//
// Parameters: ADDR_W byte address width; TIMEOUT max cycles in REQ+WAIT
// before abort (0 disables).
// Optional feature macro: LSU_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | no access in flight; latch request on dmem_req
// REQ   | bus_valid high, bus outputs held until bus_ready
// WAIT  | load accepted, waiting for bus_rvalid
// DONE  | one cycle with stall low so the core retires the access

package lsu_dmem_pkg;
    typedef enum logic [1:0] {
        OP_DMEM_BYTE = 2'd0,
        OP_DMEM_HALF = 2'd1,
        OP_DMEM_WORD = 2'd2
    } op_dmem_size;
endpackage

module lsu_dmem
    import lsu_dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmem_req,
    input  logic              dmem_wr,
    input  op_dmem_size       dmem_size,
    input  logic              dmem_zero_ex,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              stall,
    output logic              bus_err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              misalign
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

    // Down-counter loaded with TIMEOUT-1; terminal count at zero means
    // TIMEOUT cycles have been spent in REQ+WAIT.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             tc;
    logic [1:0]       off_q;
    op_dmem_size      size_q;
    logic             zex_q;

    logic             accept, capture, abort, trap;
    logic             misaligned_req;
    logic [3:0]       be_d;
    logic [31:0]      wdata_d;
    logic [31:0]      sh8, sh16, load_ext;

    assign tc        = (TIMEOUT != 0) && (cnt_q == '0);
    assign bus_valid = (state_q == ST_REQ);
    assign stall     = dmem_req && (state_q != ST_DONE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned_req = ((dmem_size == OP_DMEM_HALF) && addr[0]) ||
                            ((dmem_size != OP_DMEM_BYTE) && (dmem_size != OP_DMEM_HALF) &&
                             (addr[1:0] != 2'b00));
`else
    assign misaligned_req = 1'b0;
`endif

    // Store lane selection and data replication.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = wr_data;
        case (dmem_size)
            OP_DMEM_BYTE: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{wr_data[7:0]}};
            end
            OP_DMEM_HALF: begin
                be_d    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{wr_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction from the returned word using the latched offset/size.
    assign sh8  = bus_rdata >> {off_q, 3'b000};
    assign sh16 = bus_rdata >> {off_q[1], 4'b0000};

    always_comb begin
        load_ext = bus_rdata;
        case (size_q)
            OP_DMEM_BYTE: load_ext = zex_q ? {24'h0, sh8[7:0]} : {{24{sh8[7]}}, sh8[7:0]};
            OP_DMEM_HALF: load_ext = zex_q ? {16'h0, sh16[15:0]} : {{16{sh16[15]}}, sh16[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        trap    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dmem_req) begin
                    if (misaligned_req) begin
                        trap    = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // A handshake in the same cycle as terminal count completes normally.
                if (bus_ready) begin
                    state_d = bus_we ? ST_DONE : ST_WAIT;
                end else if (tc) begin
                    abort   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (bus_rvalid) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else if (tc) begin
                    abort   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            off_q     <= 2'b00;
            size_q    <= OP_DMEM_BYTE;
            zex_q     <= 1'b0;
            bus_addr  <= '0;
            bus_we    <= 1'b0;
            bus_be    <= 4'b0000;
            bus_wdata <= 32'h0;
            rd_data   <= 32'h0;
            bus_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            bus_err <= abort;
            if (accept) begin
                bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                bus_we    <= dmem_wr;
                bus_be    <= be_d;
                bus_wdata <= wdata_d;
                off_q     <= addr[1:0];
                size_q    <= dmem_size;
                zex_q     <= dmem_zero_ex;
                cnt_q     <= CNT_LOAD;
            end else if ((state_q == ST_REQ || state_q == ST_WAIT) && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (capture) begin
                rd_data <= load_ext;
            end else if (abort || trap) begin
                rd_data <= 32'h0;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else begin
            misalign <= trap;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_dmem.sv
// tb_lsu_dmem: directed bench for lsu_dmem. Main instance uses the default
// TIMEOUT; a second instance with TIMEOUT=4 covers the abort path.
// Covers LSU_MISALIGN_TRAP_EN when the macro is defined.

module tb_lsu_dmem;
    import lsu_dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmem_req, dmem_wr, dmem_zero_ex;
    op_dmem_size dmem_size;
    logic [31:0] addr, wr_data, rd_data;
    logic        stall, bus_err, bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    logic        to_req, to_ready, to_rvalid;
    logic [31:0] to_rd_data, to_bus_addr, to_bus_wdata;
    logic        to_stall, to_bus_err, to_bus_valid, to_bus_we;
    logic [3:0]  to_bus_be;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign, to_misalign;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_dmem #(.ADDR_W(32), .TIMEOUT(255)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_size(dmem_size),
        .dmem_zero_ex(dmem_zero_ex), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .stall(stall), .bus_err(bus_err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_we(bus_we), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
        , .misalign(misalign)
`endif
    );

    lsu_dmem #(.ADDR_W(32), .TIMEOUT(4)) u_to (
        .clk(clk), .rst_n(rst_n),
        .dmem_req(to_req), .dmem_wr(dmem_wr), .dmem_size(dmem_size),
        .dmem_zero_ex(dmem_zero_ex), .addr(addr), .wr_data(wr_data),
        .rd_data(to_rd_data), .stall(to_stall), .bus_err(to_bus_err),
        .bus_valid(to_bus_valid), .bus_ready(to_ready), .bus_addr(to_bus_addr),
        .bus_we(to_bus_we), .bus_be(to_bus_be), .bus_wdata(to_bus_wdata),
        .bus_rvalid(to_rvalid), .bus_rdata(bus_rdata)
`ifdef LSU_MISALIGN_TRAP_EN
        , .misalign(to_misalign)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one access on the main instance until stall drops (DONE cycle).
    // cyc counts cycles from the IDLE cycle through DONE inclusive.
    task automatic run_xfer(input logic wr, input op_dmem_size sz, input logic zex,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdat, input int rdy_dly, input logic noise,
                            output int cyc, output int stab_bad);
        int          req_cycles;
        logic        rv_next;
        logic [31:0] s_addr, s_wd;
        logic [3:0]  s_be;
        logic        s_we;
        dmem_req = 1'b1; dmem_wr = wr; dmem_size = sz; dmem_zero_ex = zex;
        addr = a; wr_data = wd;
        cyc = 1; req_cycles = 0; rv_next = 1'b0; stab_bad = 0;
        s_addr = '0; s_wd = '0; s_be = '0; s_we = 1'b0;
        #1;
        while (stall && cyc < 40) begin
            bus_rvalid = rv_next;
            bus_rdata  = rv_next ? rdat : 32'h5A5A_F0F0;
            rv_next    = 1'b0;
            bus_ready  = 1'b0;
            if (bus_valid) begin
                if (req_cycles == 0) begin
                    s_addr = bus_addr; s_wd = bus_wdata; s_be = bus_be; s_we = bus_we;
                end else if (bus_addr !== s_addr || bus_wdata !== s_wd ||
                             bus_be !== s_be || bus_we !== s_we) begin
                    stab_bad++;
                end
                if (req_cycles == rdy_dly) begin
                    bus_ready = 1'b1;
                    rv_next   = !wr;
                end else if (noise) begin
                    bus_rvalid = 1'b1;
                end
                req_cycles++;
            end
            step();
            cyc++;
        end
        bus_ready = 1'b0; bus_rvalid = 1'b0;
    endtask

    task automatic end_xfer();
        dmem_req = 1'b0;
        step();
        chk("idle_stall", stall, 1'b0);
    endtask

    initial begin
        int cyc, sb, errs, vcyc;
        rst_n = 1'b0; dmem_req = 1'b0; dmem_wr = 1'b0; dmem_size = OP_DMEM_BYTE;
        dmem_zero_ex = 1'b0; addr = '0; wr_data = '0; bus_ready = 1'b0;
        bus_rvalid = 1'b0; bus_rdata = '0; to_req = 1'b0; to_ready = 1'b0; to_rvalid = 1'b0;
        repeat (2) step();

        chk("rst_valid", bus_valid, 1'b0);
        chk("rst_we", bus_we, 1'b0);
        chk("rst_be", bus_be, 4'h0);
        chk("rst_addr", bus_addr, 32'h0);
        chk("rst_wdata", bus_wdata, 32'h0);
        chk("rst_rd", rd_data, 32'h0);
        chk("rst_err", bus_err, 1'b0);
        chk("rst_stall0", stall, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("rst_misalign", misalign, 1'b0);
`endif
        dmem_req = 1'b1; #1;
        chk("rst_stall1", stall, 1'b1);
        dmem_req = 1'b0; rst_n = 1'b1;
        step();

        // Store byte at 0x103
        run_xfer(1'b1, OP_DMEM_BYTE, 1'b0, 32'h103, 32'hA5, 32'h0, 0, 1'b0, cyc, sb);
        chk("sb_cyc", cyc, 3);
        chk("sb_be", bus_be, 4'b1000);
        chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);
        chk("sb_addr", bus_addr, 32'h100);
        chk("sb_we", bus_we, 1'b1);
        chk("sb_valid_done", bus_valid, 1'b0);
        end_xfer();

        // Store byte at 0x101
        run_xfer(1'b1, OP_DMEM_BYTE, 1'b0, 32'h101, 32'h0000_125C, 32'h0, 0, 1'b0, cyc, sb);
        chk("sb1_be", bus_be, 4'b0010);
        chk("sb1_wdata", bus_wdata, 32'h5C5C5C5C);
        end_xfer();

        // Store half at 0x206
        run_xfer(1'b1, OP_DMEM_HALF, 1'b0, 32'h206, 32'h1234ABCD, 32'h0, 0, 1'b0, cyc, sb);
        chk("sh_cyc", cyc, 3);
        chk("sh_be", bus_be, 4'b1100);
        chk("sh_wdata", bus_wdata, 32'hABCDABCD);
        chk("sh_addr", bus_addr, 32'h204);
        end_xfer();

        // Store word at 0x308
        run_xfer(1'b1, OP_DMEM_WORD, 1'b0, 32'h308, 32'hDEADBEEF, 32'h0, 0, 1'b0, cyc, sb);
        chk("sw_be", bus_be, 4'b1111);
        chk("sw_wdata", bus_wdata, 32'hDEADBEEF);
        chk("sw_addr", bus_addr, 32'h308);
        end_xfer();

        // Load half signed / zero-extended at 0x202
        run_xfer(1'b0, OP_DMEM_HALF, 1'b0, 32'h202, 32'h0, 32'h8001_1234, 0, 1'b0, cyc, sb);
        chk("lh_cyc", cyc, 4);
        chk("lh_rd", rd_data, 32'hFFFF8001);
        chk("lh_we", bus_we, 1'b0);
        chk("lh_err", bus_err, 1'b0);
        end_xfer();
        run_xfer(1'b0, OP_DMEM_HALF, 1'b1, 32'h202, 32'h0, 32'h8001_1234, 0, 1'b0, cyc, sb);
        chk("lhu_rd", rd_data, 32'h00008001);
        end_xfer();

        // Byte loads
        run_xfer(1'b0, OP_DMEM_BYTE, 1'b0, 32'h101, 32'h0, 32'h0000_9C00, 0, 1'b0, cyc, sb);
        chk("lb_rd", rd_data, 32'hFFFFFF9C);
        end_xfer();
        run_xfer(1'b0, OP_DMEM_BYTE, 1'b1, 32'h103, 32'h0, 32'hF234_5678, 0, 1'b0, cyc, sb);
        chk("lbu_rd", rd_data, 32'h000000F2);
        end_xfer();
        run_xfer(1'b0, OP_DMEM_BYTE, 1'b0, 32'h100, 32'h0, 32'hFFFF_FF7E, 0, 1'b0, cyc, sb);
        chk("lb_pos_rd", rd_data, 32'h0000007E);
        end_xfer();

        // A store leaves rd_data untouched
        run_xfer(1'b1, OP_DMEM_WORD, 1'b0, 32'h10, 32'h0BAD_0BAD, 32'h0, 0, 1'b0, cyc, sb);
        chk("st_hold_rd", rd_data, 32'h0000007E);
        end_xfer();

        // Word load with bus_ready low 5 cycles; stray rvalid during REQ is ignored
        run_xfer(1'b0, OP_DMEM_WORD, 1'b0, 32'h404, 32'h0, 32'hCAFE_F00D, 5, 1'b1, cyc, sb);
        chk("lw_dly_cyc", cyc, 9);
        chk("lw_dly_stable", sb, 0);
        chk("lw_dly_rd", rd_data, 32'hCAFEF00D);
        chk("lw_dly_addr", bus_addr, 32'h404);
        end_xfer();

        // Reset during WAIT, then a stray rvalid
        dmem_req = 1'b1; dmem_wr = 1'b0; dmem_size = OP_DMEM_WORD; addr = 32'h600;
        step();
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        chk("pre_rst_rd", rd_data, 32'hCAFEF00D);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus_valid, 1'b0);
        chk("mid_rst_rd", rd_data, 32'h0);
        chk("mid_rst_addr", bus_addr, 32'h0);
        dmem_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_rd", rd_data, 32'h0);
        chk("post_rst_stall", stall, 1'b0);
        chk("post_rst_valid", bus_valid, 1'b0);
        bus_rvalid = 1'b0;
        step();
        chk("post_rst_rd2", rd_data, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
        run_xfer(1'b0, OP_DMEM_WORD, 1'b0, 32'h700, 32'h0, 32'h1357_2468, 0, 1'b0, cyc, sb);
        chk("ma_pre_rd", rd_data, 32'h13572468);
        end_xfer();
        dmem_req = 1'b1; dmem_wr = 1'b0; dmem_size = OP_DMEM_WORD; addr = 32'h301;
        #1;
        chk("ma_idle_stall", stall, 1'b1);
        chk("ma_idle_valid", bus_valid, 1'b0);
        step();
        chk("ma_pulse", misalign, 1'b1);
        chk("ma_done_stall", stall, 1'b0);
        chk("ma_done_valid", bus_valid, 1'b0);
        chk("ma_rd", rd_data, 32'h0);
        dmem_req = 1'b0;
        step();
        chk("ma_clear", misalign, 1'b0);
        chk("ma_valid_after", bus_valid, 1'b0);
`else
        run_xfer(1'b0, OP_DMEM_WORD, 1'b0, 32'h301, 32'h0, 32'h89AB_CDEF, 0, 1'b0, cyc, sb);
        chk("lw_odd_rd", rd_data, 32'h89ABCDEF);
        chk("lw_odd_addr", bus_addr, 32'h300);
        chk("lw_odd_be", bus_be, 4'b1111);
        end_xfer();
        run_xfer(1'b0, OP_DMEM_HALF, 1'b1, 32'h203, 32'h0, 32'h8001_1234, 0, 1'b0, cyc, sb);
        chk("lhu_odd_rd", rd_data, 32'h00008001);
        end_xfer();
`endif

        // Timeout instance: one good load first so rd_data is nonzero
        dmem_wr = 1'b0; dmem_size = OP_DMEM_WORD; dmem_zero_ex = 1'b0; addr = 32'h500;
        to_req = 1'b1;
        step();
        to_ready = 1'b1;
        step();
        to_ready = 1'b0; to_rvalid = 1'b1; bus_rdata = 32'h1122_3344;
        step();
        chk("to_pre_rd", to_rd_data, 32'h11223344);
        to_rvalid = 1'b0; to_req = 1'b0;
        step();

        to_req = 1'b1;
        #1;
        cyc = 1; errs = 0; vcyc = 0;
        while (to_stall && cyc < 30) begin
            if (to_bus_valid) vcyc++;
            if (to_bus_err) errs++;
            step();
            cyc++;
        end
        if (to_bus_err) errs++;
        chk("to_cyc", cyc, 6);
        chk("to_valid_cycles", vcyc, 4);
        chk("to_rd", to_rd_data, 32'h0);
        chk("to_valid_done", to_bus_valid, 1'b0);
        to_req = 1'b0;
        repeat (3) begin
            step();
            if (to_bus_err) errs++;
        end
        chk("to_err_pulses", errs, 1);
        chk("to_idle_stall", to_stall, 1'b0);
        to_req = 1'b1;
        step();
        chk("to_reissue_valid", to_bus_valid, 1'b1);
        to_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
